// File: rtl/minmax_tree_pipe_pkg.sv
// Shared definitions for the min/max reduction tree.
// node_t depends on per-instance widths, so it is supplied as a macro that each module expands.
`ifndef MINMAX_NODE_T
`define MINMAX_NODE_T(IW, W) struct packed { logic is_void; logic [(IW)-1:0] idx; logic [(W)-1:0] val; }
`endif

package minmax_pkg;

    localparam logic MODE_MIN = 1'b0;
    localparam logic MODE_MAX = 1'b1;

    function automatic int node_width(input int idx_w, input int width);
        return 1 + idx_w + width;
    endfunction

endpackage

// File: rtl/minmax_tree_pipe_if.sv
// Sample-in / result-out handshake bundle for minmax_tree_pipe.
interface minmax_tree_pipe_if #(
    parameter int N     = 8,
    parameter int WIDTH = 8
);
    localparam int IDX_W = $clog2(N);

    logic               in_valid;
    logic               in_ready;
    logic               in_mode;
    logic [N*WIDTH-1:0] in_data;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   out_data;
    logic [IDX_W-1:0]   out_index;
    logic               out_mode;

    modport master (
        output in_valid, in_mode, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_index, out_mode
    );

    modport slave (
        input  in_valid, in_mode, in_data, out_ready,
        output in_ready, out_valid, out_data, out_index, out_mode
    );
endinterface

// File: rtl/minmax_tree_pipe_node.sv
// One registered comparator of the reduction tree: keeps the winner of two child nodes.
module minmax_node
    import minmax_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int IDX_W  = 3,
    parameter int SIGNED = 0
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 en,
    input  logic                                 valid,
    input  logic                                 mode,
    input  logic [node_width(IDX_W, WIDTH)-1:0]  left,
    input  logic [node_width(IDX_W, WIDTH)-1:0]  right,
    output logic [node_width(IDX_W, WIDTH)-1:0]  win
);
    typedef `MINMAX_NODE_T(IDX_W, WIDTH) node_t;

    node_t l, r, win_q;
    logic  r_less, r_greater, take_right;

    assign l   = left;
    assign r   = right;
    assign win = win_q;

    // Ties keep the left child so the lowest channel index wins; void children always lose.
    always_comb begin
        r_less    = 1'b0;
        r_greater = 1'b0;
        if (SIGNED != 0) begin
            r_less    = $signed(r.val) < $signed(l.val);
            r_greater = $signed(r.val) > $signed(l.val);
        end else begin
            r_less    = r.val < l.val;
            r_greater = r.val > l.val;
        end
        take_right = (l.is_void && !r.is_void) ||
                     (!l.is_void && !r.is_void && ((mode == MODE_MAX) ? r_greater : r_less));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_q <= '0;
        end else if (en && valid) begin
            win_q <= take_right ? r : l;
        end
    end
endmodule

// File: rtl/minmax_tree_pipe.sv
// Pipelined N-input min/max tree with winner index, one register level per tree level.
// The whole pipeline stalls together when the result is not taken, so bubbles are never squeezed out.
module minmax_tree_pipe
    import minmax_pkg::*;
#(
    parameter int N      = 8,
    parameter int WIDTH  = 8,
    parameter int SIGNED = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    minmax_tree_pipe_if.slave bus
);
    localparam int LEVELS = $clog2(N);
    localparam int IDX_W  = $clog2(N);
    localparam int LEAVES = 1 << LEVELS;
    localparam int NODE_W = node_width(IDX_W, WIDTH);

    logic [NODE_W-1:0] tree [0:LEVELS][0:LEAVES-1];
    logic              vld_q  [1:LEVELS];
    logic              mode_q [1:LEVELS];
    logic              en;

    assign en           = !(bus.out_valid && !bus.out_ready);
    assign bus.in_ready = en;

    // Valid and mode travel alongside the data through every level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int l = 1; l <= LEVELS; l++) begin
                vld_q[l]  <= 1'b0;
                mode_q[l] <= 1'b0;
            end
        end else if (en) begin
            vld_q[1]  <= bus.in_valid;
            mode_q[1] <= bus.in_mode;
            for (int l = 2; l <= LEVELS; l++) begin
                vld_q[l]  <= vld_q[l-1];
                mode_q[l] <= mode_q[l-1];
            end
        end
    end

    for (genvar k = 0; k < LEAVES; k++) begin : g_leaf
        if (k < N) begin : g_live
            assign tree[0][k] = {1'b0, IDX_W'(k), bus.in_data[k*WIDTH +: WIDTH]};
        end else begin : g_void
            assign tree[0][k] = {1'b1, IDX_W'(k), WIDTH'(0)};
        end
    end

    for (genvar lv = 1; lv <= LEVELS; lv++) begin : g_level
        localparam int COUNT = LEAVES >> lv;
        for (genvar i = 0; i < LEAVES; i++) begin : g_slot
            if (i < COUNT) begin : g_node
                logic node_valid, node_mode;
                if (lv == 1) begin : g_first
                    assign node_valid = bus.in_valid;
                    assign node_mode  = bus.in_mode;
                end else begin : g_inner
                    assign node_valid = vld_q[lv-1];
                    assign node_mode  = mode_q[lv-1];
                end
                minmax_node #(
                    .WIDTH (WIDTH),
                    .IDX_W (IDX_W),
                    .SIGNED(SIGNED)
                ) u_node (
                    .clk  (clk),
                    .rst_n(rst_n),
                    .en   (en),
                    .valid(node_valid),
                    .mode (node_mode),
                    .left (tree[lv-1][2*i]),
                    .right(tree[lv-1][2*i+1]),
                    .win  (tree[lv][i])
                );
            end else begin : g_unused
                assign tree[lv][i] = '0;
            end
        end
    end

    assign bus.out_valid = vld_q[LEVELS];
    assign bus.out_mode  = mode_q[LEVELS];
    assign bus.out_data  = tree[LEVELS][0][WIDTH-1:0];
    assign bus.out_index = tree[LEVELS][0][WIDTH +: IDX_W];
endmodule

// File: doc/minmax_tree_pipe.md
Name: minmax_tree_pipe

Overview:
- Parametrised, pipelined N-input minimum/maximum reduction tree with per-sample mode select (min or max) and winner-index output.
- One registered comparator level per tree level, valid/ready handshake with full-pipeline stall on backpressure.
- Generalises the three-input registered min block to arbitrary width, input count, signedness and mode.
- Sits between a multi-channel sample source and downstream selection or arbitration logic.

Parameters:
- N, 8, number of input channels; legal range 2..64, need not be a power of two.
- WIDTH, 8, bits per channel value.
- SIGNED, 0, 0 = unsigned compare, 1 = two's-complement compare.
- LEVELS, derived $clog2(N), tree depth and pipeline latency. Not overridable.
- IDX_W, derived $clog2(N), width of the winner index. Not overridable.

Ports:
- clk  in  1  clock; all state on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input sample present.
- in_ready  out  1  block accepts a sample this cycle.
- in_mode  in  1  0 = min, 1 = max. Applies to the sample it arrives with.
- in_data  in  N*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
- out_valid  out  1  result present.
- out_ready  in  1  downstream accepts the result.
- out_data  out  WIDTH  winning value.
- out_index  out  IDX_W  channel number of the winner.
- out_mode  out  1  mode the result was computed with.

Behaviour:
- Reset (rst_n low, asynchronous): all pipeline valid bits, data, index and mode registers clear to 0, so out_valid=0, out_data=0, out_index=0, out_mode=0. in_ready is 1 while out_valid=0.
- Reset mid-operation discards all in-flight samples. No partial result is emitted after reset releases.
- Handshake:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
  - stall = out_valid && !out_ready; in_ready = !stall.
  - When stalled, every pipeline stage holds its contents, and out_data, out_index and out_mode stay stable.
  - in_ready does not depend on in_valid.
- Throughput and latency: one sample per cycle with no stall. A sample accepted at edge t appears with out_valid=1 after edge t+LEVELS-1, i.e. LEVELS register stages (LEVELS=3 for N=8).
- Bubbles: a stage whose input valid is 0 loads valid=0. Bubbles propagate and are never squeezed out, because the pipeline is global-stall only.
- Tree structure:
  - Level 0 has 2^LEVELS leaves.
  - Leaves k >= N are void: a void flag is set and the leaf always loses.
  - Each node compares its left child (lower indices) and right child (higher indices) and registers the winner's value, index and void flag.
  - The mode bit travels with the sample through every stage.
- Selection rule:
  - Min mode: the right child wins only if right < left.
  - Max mode: the right child wins only if right > left.
  - Ties go to the left child, so the lowest channel index wins on equal values.
  - A void child loses to a non-void child. Two void children produce a void node.
  - The root is never void, since N >= 2.
- Arithmetic: compare is on full WIDTH, signed or unsigned per SIGNED. There are no width changes. out_data is a bit-exact copy of the winning input channel.
- Simultaneous input accept and output accept in the same cycle is legal and sustains full throughput.

Decomposition:
- Shared package minmax_pkg:
  - MODE_MIN=1'b0 and MODE_MAX=1'b1 constants.
  - Packed struct node_t {void, idx[IDX_W], val[WIDTH]}; the package is parametrised via a macro or param class.
- Sub-module minmax_node:
  - One registered comparator taking two node_t values plus mode, valid and enable.
  - Produces the registered winner.
  - The top level instantiates a generate tree of minmax_node and the stall/ready logic.

Test Plan:
- N=8, WIDTH=8, unsigned, min: data {5,3,9,3,7,8,6,4} (ch0..7), single sample → after 3 cycles out_valid=1, out_data=3, out_index=1, out_mode=0.
- Same data, max, followed the next cycle by all-0xFF in min mode → results 9/idx 2 then 0xFF/idx 0, on consecutive cycles.
- Backpressure: stream 6 samples with out_ready=0 from cycle 4 to cycle 8 → in_ready=0 while stalled, outputs held stable, all 6 results delivered in order with none lost or duplicated.
- N=3, WIDTH=8, max: {0x00,0x00,0x00} → out_data=0, out_index=0 (the void leaf never wins); {1,2,2} → 2, idx 1.
- SIGNED=1, WIDTH=4, min: {0x7,0x8,0x1,0xF} → out_data=0x8 (−8), out_index=1; max of the same → 0x7, idx 0.
- Reset asserted asynchronously with 2 samples in flight → out_valid drops immediately and no stale result appears after reset release; the next sample has correct latency.
